mbus_ice_driver_rx: RTL and testbench
=====================================

Name: mbus_ice_driver_rx

Overview:
Receive-direction MBus driver for the ICE bridge. Accepts 32-bit address/data words from the MBus layer controller with a 4-phase req/ack handshake. Serializes each message into an MSB-first byte frame for the ICE bus interface: address bytes, then data bytes, then one status byte. It is the counterpart of the transmit driver and feeds the same byte-oriented frame path back toward the host.

Parameters:
SHORT_ADDR_EN, 1, when 1 and rxaddr[31:28]!=4'hF only rxaddr[7:0] is emitted (1 address byte); otherwise all 4 address bytes are emitted.
STATUS_OK, 8'h00, status byte for a message that completes normally.
STATUS_FAIL, 8'h01, status byte for a message aborted by rx_mbus_rxfail.

Ports:
clk  in  1  single clock; all state on rising edge.
reset_n  in  1  asynchronous, active-low reset.
rx_mbus_rxaddr  in  32  message address; valid with rxreq on the first word of a message.
rx_mbus_rxdata  in  32  data word; valid with rxreq.
rx_mbus_rxreq  in  1  word-available request (level; 4-phase).
rx_mbus_rxpend  in  1  valid with rxreq: 1 means more words follow in this message.
rx_mbus_rxfail  in  1  message abort indication (level or pulse).
rx_mbus_rxack  out  1  word-accept acknowledge (registered).
rx_frame_valid  out  1  high from the first byte of a frame through the status-byte transfer.
rx_char  out  8  output byte.
rx_char_valid  out  1  rx_char is valid.
rx_char_ready  in  1  sink accepts the byte; a transfer occurs when valid and ready are both 1.

Behaviour:
- Reset: async on reset_n low. rxack=0, rx_frame_valid=0, rx_char=0, rx_char_valid=0, state=IDLE, byte counter=0, fail flag=0, latched addr/data/pend=0.
- States:
  - IDLE: on rxreq=1, latch addr, data and pend, set first=1, go to ACK. rxfail in IDLE is ignored.
  - ACK: rxack=1 until rxreq samples 0, then rxack=0 the next cycle. Go to SHIFT_ADDR if first=1, else SHIFT_DATA. Byte output does not start before the handshake completes.
  - SHIFT_ADDR: emit 1 or 4 address bytes, MSB first, then go to SHIFT_DATA.
  - SHIFT_DATA: emit 4 data bytes, MSB first. After the last byte transfers:
    - fail flag set → STATUS;
    - latched pend=1 → WAIT_NEXT;
    - otherwise → STATUS.
  - WAIT_NEXT: rx_frame_valid stays 1.
    - rxfail=1 → set fail flag, go to STATUS.
    - rxreq=1 → latch data and pend, first=0, go to ACK.
    - Both at once: accept and acknowledge the word, set fail flag, shift that word, then emit STATUS_FAIL.
  - STATUS: emit STATUS_FAIL if the fail flag is set, else STATUS_OK. On transfer: rx_frame_valid=0 and rx_char_valid=0 on the next cycle, fail flag cleared, go to IDLE.
- Byte handshake:
  - rx_char and rx_char_valid are registered.
  - The first byte is valid 1 cycle after entering a SHIFT state.
  - While valid=1 and ready=0, rx_char holds stable.
  - With ready held at 1, one byte transfers per cycle (back-to-back).
  - The byte counter is 2 bits; it advances only on a transfer and wraps to 0 at each word boundary.
- rx_frame_valid rises with the first rx_char_valid of a frame.
- rxfail arriving during ACK or SHIFT sets a sticky fail flag. The current word finishes shifting, then the status byte is emitted. Bytes already presented are never retracted.
- rxreq is never acknowledged while bytes of a previous word are pending (single-word buffer).
- Reset mid-frame: all outputs return to their reset values immediately; the partial frame is dropped.
- Default/illegal state → IDLE with all outputs deasserted.

Decomposition:
- Shared include (ice_def): state encodings ST_RX_IDLE, ST_RX_ACK, ST_RX_SHIFT_ADDR, ST_RX_SHIFT_DATA, ST_RX_WAIT_NEXT, ST_RX_STATUS; default STATUS_OK/STATUS_FAIL codes; the full-address prefix 4'hF.
- Optional sub-module mbus_ice_byte_ser: loads a 32-bit word plus a byte count (1 or 4) and serializes it MSB first over valid/ready. All other logic stays in one FSM.

Test Plan:
- Short-address single word: addr=32'h0000_0051, data=32'hDEAD_BEEF, pend=0, ready=1 → bytes 51 DE AD BE EF 00. rxack pulses once. rx_frame_valid is high for exactly 6 transfers.
- Full address: addr=32'hF012_3456, data=32'h0102_0304 → F0 12 34 56 01 02 03 04 00.
- Two-word message: word0 pend=1 data=32'h1111_2222, word1 pend=0 data=32'h3333_4444, addr=32'h0000_0020 → 20 11 11 22 22 33 33 44 44 00. rxack is not asserted for word1 until byte 22 (last) has transferred.
- Fail in WAIT_NEXT: word0 pend=1, then rxfail=1 → 5 bytes then 01. No second rxack; rx_frame_valid drops after the 01 byte.
- Backpressure: ready toggled 1,0,0,1 through a frame → rx_char stable while stalled, no duplicated or lost bytes, frame identical to the first test.
- Reset mid-frame: reset_n low after 2 bytes → rxack, rx_char_valid and rx_frame_valid are 0 asynchronously. The next message produces a clean frame.

Source files
------------

// File: rtl/mbus_ice_driver_rx_pkg.sv
// Shared definitions for the MBus-to-ICE receive driver: FSM state encoding,
// default status codes, the full-address prefix and a byte-select helper.
package mbus_ice_driver_rx_pkg;

  typedef enum logic [2:0] {
    ST_RX_IDLE       = 3'd0,
    ST_RX_ACK        = 3'd1,
    ST_RX_SHIFT_ADDR = 3'd2,
    ST_RX_SHIFT_DATA = 3'd3,
    ST_RX_WAIT_NEXT  = 3'd4,
    ST_RX_STATUS     = 3'd5
  } rx_state_e;

  localparam logic [7:0] STATUS_OK_DEFAULT   = 8'h00;
  localparam logic [7:0] STATUS_FAIL_DEFAULT = 8'h01;
  localparam logic [3:0] FULL_ADDR_PREFIX    = 4'hF;

  // Byte idx of a word counted from the MSB (idx 0 = bits 31:24).
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/mbus_ice_driver_rx.sv
// Receive-direction MBus driver: accepts address/data words over a 4-phase
// req/ack handshake and serializes them MSB first into an ICE byte frame.
module mbus_ice_driver_rx
  import mbus_ice_driver_rx_pkg::*;
#(
  parameter bit         SHORT_ADDR_EN = 1'b1,
  parameter logic [7:0] STATUS_OK     = STATUS_OK_DEFAULT,
  parameter logic [7:0] STATUS_FAIL   = STATUS_FAIL_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rx_mbus_rxaddr,
  input  logic [31:0] rx_mbus_rxdata,
  input  logic        rx_mbus_rxreq,
  input  logic        rx_mbus_rxpend,
  input  logic        rx_mbus_rxfail,
  output logic        rx_mbus_rxack,
  output logic        rx_frame_valid,
  output logic [7:0]  rx_char,
  output logic        rx_char_valid,
  input  logic        rx_char_ready
);

  rx_state_e   state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        pend_q;
  logic        first_q;
  logic        fail_q;
  logic [1:0]  cnt_q;

  logic        short_addr;
  logic [1:0]  cnt_nxt;
  logic        addr_last;
  logic        data_last;
  logic [7:0]  addr_byte;
  logic [7:0]  addr_byte_nxt;
  logic [7:0]  data_byte;
  logic [7:0]  data_byte_nxt;

  assign short_addr    = SHORT_ADDR_EN && (addr_q[31:28] != FULL_ADDR_PREFIX);
  assign cnt_nxt       = cnt_q + 2'd1;
  assign addr_last     = short_addr || (cnt_q == 2'd3);
  assign data_last     = (cnt_q == 2'd3);
  assign addr_byte     = short_addr ? addr_q[7:0] : word_byte(addr_q, cnt_q);
  assign addr_byte_nxt = word_byte(addr_q, cnt_nxt);
  assign data_byte     = word_byte(data_q, cnt_q);
  assign data_byte_nxt = word_byte(data_q, cnt_nxt);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the latched words are reset too, so a frame dropped by reset
    // leaves no stale address/data behind for the next message.
    if (!reset_n) begin
      state          <= ST_RX_IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      pend_q         <= 1'b0;
      first_q        <= 1'b0;
      fail_q         <= 1'b0;
      cnt_q          <= 2'd0;
      rx_mbus_rxack  <= 1'b0;
      rx_frame_valid <= 1'b0;
      rx_char        <= 8'h00;
      rx_char_valid  <= 1'b0;
    end else begin
      case (state)
        ST_RX_IDLE: begin
          if (rx_mbus_rxreq) begin
            addr_q        <= rx_mbus_rxaddr;
            data_q        <= rx_mbus_rxdata;
            pend_q        <= rx_mbus_rxpend;
            first_q       <= 1'b1;
            rx_mbus_rxack <= 1'b1;
            state         <= ST_RX_ACK;
          end
        end

        ST_RX_ACK: begin
          if (rx_mbus_rxfail) fail_q <= 1'b1;
          if (!rx_mbus_rxreq) begin
            rx_mbus_rxack <= 1'b0;
            state         <= first_q ? ST_RX_SHIFT_ADDR : ST_RX_SHIFT_DATA;
          end
        end

        ST_RX_SHIFT_ADDR: begin
          if (rx_mbus_rxfail) fail_q <= 1'b1;
          if (!rx_char_valid) begin
            rx_char        <= addr_byte;
            rx_char_valid  <= 1'b1;
            rx_frame_valid <= 1'b1;
          end else if (rx_char_ready) begin
            if (addr_last) begin
              cnt_q         <= 2'd0;
              rx_char_valid <= 1'b0;
              state         <= ST_RX_SHIFT_DATA;
            end else begin
              cnt_q   <= cnt_nxt;
              rx_char <= addr_byte_nxt;
            end
          end
        end

        ST_RX_SHIFT_DATA: begin
          if (rx_mbus_rxfail) fail_q <= 1'b1;
          if (!rx_char_valid) begin
            rx_char        <= data_byte;
            rx_char_valid  <= 1'b1;
            rx_frame_valid <= 1'b1;
          end else if (rx_char_ready) begin
            if (data_last) begin
              cnt_q         <= 2'd0;
              rx_char_valid <= 1'b0;
              // A fail seen on this very cycle still ends the message.
              if (fail_q || rx_mbus_rxfail || !pend_q) state <= ST_RX_STATUS;
              else                                     state <= ST_RX_WAIT_NEXT;
            end else begin
              cnt_q   <= cnt_nxt;
              rx_char <= data_byte_nxt;
            end
          end
        end

        ST_RX_WAIT_NEXT: begin
          if (rx_mbus_rxreq) begin
            data_q        <= rx_mbus_rxdata;
            pend_q        <= rx_mbus_rxpend;
            first_q       <= 1'b0;
            rx_mbus_rxack <= 1'b1;
            if (rx_mbus_rxfail) fail_q <= 1'b1;
            state         <= ST_RX_ACK;
          end else if (rx_mbus_rxfail) begin
            fail_q <= 1'b1;
            state  <= ST_RX_STATUS;
          end
        end

        ST_RX_STATUS: begin
          if (!rx_char_valid) begin
            rx_char       <= fail_q ? STATUS_FAIL : STATUS_OK;
            rx_char_valid <= 1'b1;
          end else if (rx_char_ready) begin
            rx_char_valid  <= 1'b0;
            rx_frame_valid <= 1'b0;
            fail_q         <= 1'b0;
            state          <= ST_RX_IDLE;
          end
        end

        default: begin
          state          <= ST_RX_IDLE;
          fail_q         <= 1'b0;
          cnt_q          <= 2'd0;
          rx_mbus_rxack  <= 1'b0;
          rx_frame_valid <= 1'b0;
          rx_char        <= 8'h00;
          rx_char_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_ice_driver_rx.sv
// Self-checking bench for mbus_ice_driver_rx: directed vector table, randomized
// messages against a frame-level reference model, and reset/idle-fail sequences.
module tb_mbus_ice_driver_rx;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [31:0]      addr;
    logic [2:0][31:0] data;
    int               nwords;
    int               fmode;  // 0 none, 1 fail during first ACK, 2 fail in WAIT_NEXT, 3 req+fail together
    int               rmode;  // 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready
  } msg_t;

  typedef struct {
    msg_t         m;
    int           exp_len;
    logic [127:0] exp_bytes;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rx_mbus_rxaddr = '0;
  logic [31:0] rx_mbus_rxdata = '0;
  logic        rx_mbus_rxreq = 1'b0;
  logic        rx_mbus_rxpend = 1'b0;
  logic        rx_mbus_rxfail = 1'b0;
  logic        rx_mbus_rxack;
  logic        rx_frame_valid;
  logic [7:0]  rx_char;
  logic        rx_char_valid;
  logic        rx_char_ready = 1'b1;

  int   n_cmp = 0;
  int   n_bad = 0;
  bq_t  got;
  int   rmode = 0;
  int   pat_idx = 0;
  int   fv_bad = 0;
  int   ack_rises = 0;
  logic ack_prev = 1'b0;
  logic stalled = 1'b0;
  logic [7:0] stall_char = 8'h00;

  always #5 clk = ~clk;

  mbus_ice_driver_rx #(.SHORT_ADDR_EN(1'b1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_mbus_rxaddr (rx_mbus_rxaddr),
    .rx_mbus_rxdata (rx_mbus_rxdata),
    .rx_mbus_rxreq  (rx_mbus_rxreq),
    .rx_mbus_rxpend (rx_mbus_rxpend),
    .rx_mbus_rxfail (rx_mbus_rxfail),
    .rx_mbus_rxack  (rx_mbus_rxack),
    .rx_frame_valid (rx_frame_valid),
    .rx_char        (rx_char),
    .rx_char_valid  (rx_char_valid),
    .rx_char_ready  (rx_char_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte sink: drives ready on the falling edge and records each byte that
  // will transfer on the following rising edge.
  always @(negedge clk) begin
    logic nr;
    if (!reset_n) begin
      stalled  = 1'b0;
      ack_prev = 1'b0;
    end else begin
      if (rx_mbus_rxack && !ack_prev) ack_rises++;
      ack_prev = rx_mbus_rxack;
      if (rx_frame_valid && !rx_char_valid && got.size() == 0) fv_bad++;
      if (stalled) begin
        check("stall_valid_held", {31'd0, rx_char_valid}, 32'd1);
        check("stall_char_held", {24'd0, rx_char}, {24'd0, stall_char});
      end
      case (rmode)
        0:       nr = 1'b1;
        1:       begin nr = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); pat_idx++; end
        default: nr = 1'($urandom_range(0, 1));
      endcase
      rx_char_ready = nr;
      if (rx_char_valid && nr) begin
        got.push_back(rx_char);
        if (!rx_frame_valid) fv_bad++;
      end
      stalled    = rx_char_valid && !nr;
      stall_char = rx_char;
    end
  end

  // Reference frame: address bytes (1 for short addresses, else 4), four bytes
  // per accepted word, then the status byte.
  function automatic bq_t model_frame(input msg_t m);
    bq_t q;
    int  nab;
    nab = (m.addr[31:28] != 4'hF) ? 1 : 4;
    for (int i = 0; i < nab; i++) q.push_back(8'((m.addr >> (8 * (nab - 1 - i))) & 32'hFF));
    for (int w = 0; w < m.nwords; w++)
      for (int i = 0; i < 4; i++) q.push_back(8'((m.data[w] >> (8 * (3 - i))) & 32'hFF));
    q.push_back((m.fmode != 0) ? 8'h01 : 8'h00);
    return q;
  endfunction

  task automatic wait_ack(input logic lvl, input string name);
    int c = 0;
    while (rx_mbus_rxack !== lvl && c < 100) begin
      @(negedge clk);
      c++;
    end
    check(name, {31'd0, rx_mbus_rxack}, {31'd0, lvl});
  endtask

  task automatic wait_bytes(input int n, input string name);
    int c = 0;
    while (got.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    check(name, {31'd0, got.size() >= n}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d, input logic p,
                           input logic f, input int bytes_before);
    @(negedge clk);
    rx_mbus_rxaddr = a;
    rx_mbus_rxdata = d;
    rx_mbus_rxpend = p;
    rx_mbus_rxfail = f;
    rx_mbus_rxreq  = 1'b1;
    wait_ack(1'b1, "ack_rise");
    check("bytes_before_ack", got.size(), bytes_before);
    rx_mbus_rxreq = 1'b0;
    wait_ack(1'b0, "ack_fall");
    rx_mbus_rxfail = 1'b0;
  endtask

  task automatic run_frame(input string tag, input msg_t m, input bq_t exp_q);
    int   nab;
    int   c;
    int   last;
    logic p;
    got.delete();
    ack_rises = 0;
    fv_bad    = 0;
    pat_idx   = 0;
    rmode     = m.rmode;
    nab  = (m.addr[31:28] != 4'hF) ? 1 : 4;
    last = m.nwords - 1;
    for (int w = 0; w < m.nwords; w++) begin
      if (w < last)          p = 1'b1;
      else if (m.fmode == 0) p = 1'b0;
      else if (m.fmode == 2) p = 1'b1;
      else                   p = 1'($urandom_range(0, 1));
      if (m.fmode == 3 && w == last) begin
        wait_bytes(nab + 4 * w, {tag, "_drain_before_req"});
        repeat (2) @(negedge clk);
      end
      send_word(m.addr, m.data[w], p, (m.fmode == 1 && w == 0) || (m.fmode == 3 && w == last),
                (w == 0) ? 0 : nab + 4 * w);
    end
    if (m.fmode == 2) begin
      wait_bytes(nab + 4 * m.nwords, {tag, "_drain_before_fail"});
      repeat (2) @(negedge clk);
      rx_mbus_rxfail = 1'b1;
      @(negedge clk);
      rx_mbus_rxfail = 1'b0;
    end
    c = 0;
    while ((got.size() < exp_q.size() || rx_frame_valid) && c < 400) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF,
            {24'd0, exp_q[i]});
    check({tag, "_ack_count"}, ack_rises, m.nwords);
    check({tag, "_frame_valid_bad"}, fv_bad, 0);
    check({tag, "_frame_valid_end"}, {31'd0, rx_frame_valid}, 32'd0);
    check({tag, "_char_valid_end"}, {31'd0, rx_char_valid}, 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                              input int nw, input int fm, input int rm, input int len,
                              input logic [127:0] eb);
    vec_t v;
    v.m.addr    = a;
    v.m.data    = {32'd0, d1, d0};
    v.m.nwords  = nw;
    v.m.fmode   = fm;
    v.m.rmode   = rm;
    v.exp_len   = len;
    v.exp_bytes = eb;
    return v;
  endfunction

  initial begin
    vec_t         vecs[8];
    bq_t          eq;
    msg_t         m;
    logic [127:0] tmp;
    int           r;

    vecs[0] = mk(32'h0000_0051, 32'hDEAD_BEEF, 32'h0, 1, 0, 0, 6, 128'h51_DEAD_BEEF_00);
    vecs[1] = mk(32'hF012_3456, 32'h0102_0304, 32'h0, 1, 0, 0, 9, 128'hF0_1234_56_0102_0304_00);
    vecs[2] = mk(32'h0000_0020, 32'h1111_2222, 32'h3333_4444, 2, 0, 0, 10,
                 128'h20_1111_2222_3333_4444_00);
    vecs[3] = mk(32'h0000_0020, 32'h1111_2222, 32'h0, 1, 2, 0, 6, 128'h20_1111_2222_01);
    vecs[4] = mk(32'h0000_0051, 32'hDEAD_BEEF, 32'h0, 1, 0, 1, 6, 128'h51_DEAD_BEEF_00);
    vecs[5] = mk(32'h0000_00A5, 32'h0123_4567, 32'h89AB_CDEF, 2, 3, 0, 10,
                 128'hA5_0123_4567_89AB_CDEF_01);
    vecs[6] = mk(32'hF000_0001, 32'hCAFE_BABE, 32'h0, 1, 1, 0, 9, 128'hF0_0000_01_CAFE_BABE_01);
    vecs[7] = mk(32'hFFFF_0000, 32'hA0A1_A2A3, 32'hB0B1_B2B3, 2, 0, 2, 13,
                 128'hFFFF_0000_A0A1_A2A3_B0B1_B2B3_00);

    #12;
    check("reset_rxack", {31'd0, rx_mbus_rxack}, 32'd0);
    check("reset_frame_valid", {31'd0, rx_frame_valid}, 32'd0);
    check("reset_char_valid", {31'd0, rx_char_valid}, 32'd0);
    check("reset_char", {24'd0, rx_char}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      eq.delete();
      for (int i = 0; i < vecs[v].exp_len; i++) begin
        tmp = vecs[v].exp_bytes >> (8 * (vecs[v].exp_len - 1 - i));
        eq.push_back(tmp[7:0]);
      end
      run_frame($sformatf("vec%0d", v), vecs[v].m, eq);
    end

    // rxfail while idle must not taint the next message.
    @(negedge clk);
    rx_mbus_rxfail = 1'b1;
    repeat (3) @(negedge clk);
    rx_mbus_rxfail = 1'b0;
    m.addr = 32'h0000_0042; m.data = {32'd0, 32'd0, 32'h5566_7788};
    m.nwords = 1; m.fmode = 0; m.rmode = 0;
    run_frame("idle_fail", m, model_frame(m));

    // Reset in the middle of a frame.
    got.delete();
    rmode = 0;
    @(negedge clk);
    rx_mbus_rxaddr = 32'h0000_0077;
    rx_mbus_rxdata = 32'h1234_5678;
    rx_mbus_rxpend = 1'b0;
    rx_mbus_rxreq  = 1'b1;
    wait_ack(1'b1, "rst_ack_rise");
    rx_mbus_rxreq = 1'b0;
    wait_ack(1'b0, "rst_ack_fall");
    r = 0;
    while (got.size() < 2 && r < 50) begin
      @(posedge clk);
      r++;
    end
    #2;
    check("rst_mid_valid_before", {31'd0, rx_char_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_rxack", {31'd0, rx_mbus_rxack}, 32'd0);
    check("rst_mid_char_valid", {31'd0, rx_char_valid}, 32'd0);
    check("rst_mid_frame_valid", {31'd0, rx_frame_valid}, 32'd0);
    check("rst_mid_char", {24'd0, rx_char}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    m.addr = 32'h0000_0033; m.data = {32'd0, 32'd0, 32'hCAFE_F00D};
    m.nwords = 1; m.fmode = 0; m.rmode = 0;
    run_frame("post_rst", m, model_frame(m));

    // Randomized messages against the frame model.
    for (int k = 0; k < 24; k++) begin
      m.addr = $urandom;
      if ($urandom_range(0, 1) == 1) m.addr[31:28] = 4'hF;
      for (int w = 0; w < 3; w++) m.data[w] = $urandom;
      r = $urandom_range(0, 5);
      m.fmode = (r < 3) ? 0 : r - 2;
      if (m.fmode == 1)      m.nwords = 1;
      else if (m.fmode == 3) m.nwords = $urandom_range(2, 3);
      else                   m.nwords = $urandom_range(1, 3);
      m.rmode = $urandom_range(0, 2);
      run_frame($sformatf("rnd%0d", k), m, model_frame(m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
